// File: rtl/track_mixer.sv
// track_mixer: N-track mono mixer with per-track gain, mute and solo.
// A frame strobe snapshots every track sample and control. One multiplier
// is then time-shared across the tracks, one track per cycle. The sum is
// scaled down by the gain fraction and saturated to the sample width.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous reset, active low
//   i_sample_valid one-cycle frame strobe (synchronous to i_clk)
//   i_track_data   packed signed samples, track k at [k*WORD_WIDTH +: WORD_WIDTH]
//   i_track_gain   packed unsigned gains, track k at [k*GAIN_WIDTH +: GAIN_WIDTH]
//   i_mute         1 = track silenced (wins over solo)
//   i_solo         1 = track soloed
//   i_flag_clear   clears the sticky clip/overrun flags
//   o_mix_out      saturated mix; holds its value between frames
//   o_mix_valid    one-cycle pulse when o_mix_out updates
//   o_busy         a frame is being computed
//   o_clip         sticky: a frame saturated
//   o_overrun      sticky: a strobe arrived while busy and was dropped
//
// state  | meaning
// IDLE   | waiting for a frame strobe
// ACCUM  | one track per cycle through the multiplier
// SAT    | scale, saturate and publish the mix
module track_mixer #(
  parameter int WORD_WIDTH = 8,
  parameter int N_TRACKS   = 4,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_FRAC  = 6
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_sample_valid,
  input  logic [N_TRACKS*WORD_WIDTH-1:0] i_track_data,
  input  logic [N_TRACKS*GAIN_WIDTH-1:0] i_track_gain,
  input  logic [N_TRACKS-1:0]            i_mute,
  input  logic [N_TRACKS-1:0]            i_solo,
  input  logic                           i_flag_clear,
  output logic [WORD_WIDTH-1:0]          o_mix_out,
  output logic                           o_mix_valid,
  output logic                           o_busy,
  output logic                           o_clip,
  output logic                           o_overrun
);

  localparam int PROD_W = WORD_WIDTH + GAIN_WIDTH + 1;
  // Headroom for N_TRACKS worst-case products, so the sum cannot wrap.
  localparam int ACC_W  = PROD_W + $clog2(N_TRACKS) + 1;
  localparam int IDX_W  = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TRACKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_SAT   = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WORD_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]                   r_state;
  logic [IDX_W-1:0]             r_idx;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [WORD_WIDTH-1:0] r_samp [N_TRACKS];
  logic [GAIN_WIDTH-1:0]        r_gain [N_TRACKS];
  logic [N_TRACKS-1:0]          r_active;
  logic [WORD_WIDTH-1:0]        r_mix_out;
  logic                         r_mix_valid;
  logic                         r_clip;
  logic                         r_overrun;

  logic [N_TRACKS-1:0]          w_active;
  logic signed [PROD_W-1:0]     w_samp_x;
  logic signed [PROD_W-1:0]     w_gain_x;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_prod_x;
  logic signed [ACC_W-1:0]      w_shift;
  logic                         w_over;
  logic                         w_under;
  logic                         w_busy;

  // Mute/solo are folded into one enable bit per track at snapshot time.
  always_comb begin
    w_active = '0;
    for (int k = 0; k < N_TRACKS; k++) begin
      w_active[k] = ~i_mute[k] & ((i_solo == '0) | i_solo[k]);
    end
  end

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign w_samp_x = {{(GAIN_WIDTH + 1){r_samp[r_idx][WORD_WIDTH-1]}}, r_samp[r_idx]};
  assign w_gain_x = {{(WORD_WIDTH + 1){1'b0}}, r_gain[r_idx]};
  assign w_prod   = w_samp_x * w_gain_x;
  assign w_prod_x = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Arithmetic shift floors toward -inf.
  assign w_shift  = r_acc >>> GAIN_FRAC;
  assign w_over   = (w_shift > SAT_MAX);
  assign w_under  = (w_shift < SAT_MIN);
  assign w_busy   = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_active    <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_clip      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int k = 0; k < N_TRACKS; k++) begin
        r_samp[k] <= '0;
        r_gain[k] <= '0;
      end
    end else begin
      r_mix_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_sample_valid) begin
            for (int k = 0; k < N_TRACKS; k++) begin
              r_samp[k] <= i_track_data[k*WORD_WIDTH +: WORD_WIDTH];
              r_gain[k] <= i_track_gain[k*GAIN_WIDTH +: GAIN_WIDTH];
            end
            r_active <= w_active;
            r_acc    <= '0;
            r_idx    <= '0;
            r_state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (r_active[r_idx]) begin
            r_acc <= r_acc + w_prod_x;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_SAT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_SAT: begin
          if (w_over) begin
            r_mix_out <= {1'b0, {(WORD_WIDTH - 1){1'b1}}};
          end else if (w_under) begin
            r_mix_out <= {1'b1, {(WORD_WIDTH - 1){1'b0}}};
          end else begin
            r_mix_out <= w_shift[WORD_WIDTH-1:0];
          end
          r_mix_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Set wins over a simultaneous clear.
      r_clip    <= ((r_state == S_SAT) & (w_over | w_under)) | (r_clip & ~i_flag_clear);
      r_overrun <= (i_sample_valid & w_busy) | (r_overrun & ~i_flag_clear);
    end
  end

  assign o_mix_out   = r_mix_out;
  assign o_mix_valid = r_mix_valid;
  assign o_busy      = w_busy;
  assign o_clip      = r_clip;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_track_mixer.sv
module tb_track_mixer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int G  = 8;
  localparam int GF = 6;

  logic           clk;
  logic           rst;
  logic           sample_valid;
  logic [N*W-1:0] track_data;
  logic [N*G-1:0] track_gain;
  logic [N-1:0]   mute;
  logic [N-1:0]   solo;
  logic           flag_clear;
  logic [W-1:0]   mix_out;
  logic           mix_valid;
  logic           busy;
  logic           clip;
  logic           overrun;

  int n_cmp = 0;
  int n_bad = 0;

  track_mixer #(.WORD_WIDTH(W), .N_TRACKS(N), .GAIN_WIDTH(G), .GAIN_FRAC(GF)) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(sample_valid),
    .i_track_data(track_data), .i_track_gain(track_gain),
    .i_mute(mute), .i_solo(solo), .i_flag_clear(flag_clear),
    .o_mix_out(mix_out), .o_mix_valid(mix_valid), .o_busy(busy),
    .o_clip(clip), .o_overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int e);
    logic [7:0] pa, pb, pc, pe;
    pa = 8'(a); pb = 8'(b); pc = 8'(c); pe = 8'(e);
    return {pe, pc, pb, pa};
  endfunction

  // Mix rule straight from arithmetic: sum of active sample*gain, floor-divide
  // by 2^GF, clamp to the signed word range.
  task automatic model_mix(input logic [N*W-1:0] d, input logic [N*G-1:0] g,
                           input logic [N-1:0] m, input logic [N-1:0] s,
                           output int res, output bit clipped);
    int sum, r, hi, lo;
    sum = 0;
    for (int k = 0; k < N; k++) begin
      logic signed [W-1:0] sv;
      logic [G-1:0] gv;
      sv = d[k*W +: W];
      gv = g[k*G +: G];
      if (!m[k] && (s == '0 || s[k])) sum += int'(sv) * int'(gv);
    end
    r  = sum >>> GF;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    clipped = 1'b0;
    res = r;
    if (r > hi) begin res = hi; clipped = 1'b1; end
    else if (r < lo) begin res = lo; clipped = 1'b1; end
  endtask

  // Cycle-level expectations: a frame occupies N+1 busy cycles after the
  // accepting edge; the result appears on the edge that ends the busy window.
  int m_left = 0;
  int m_res = 0;
  bit m_rclip = 0;
  int e_out = 0;
  bit e_valid = 0, e_clip = 0, e_over = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; e_out = 0; e_valid = 0; e_clip = 0; e_over = 0;
    end else begin
      bit set_clip, set_over;
      set_clip = 0; set_over = 0; e_valid = 0;
      if (m_left > 0) begin
        if (sample_valid) set_over = 1;
        m_left--;
        if (m_left == 0) begin
          e_valid = 1; e_out = m_res; set_clip = m_rclip;
        end
      end else if (sample_valid) begin
        model_mix(track_data, track_gain, mute, solo, m_res, m_rclip);
        m_left = N + 1;
      end
      e_clip = set_clip | (e_clip & ~flag_clear);
      e_over = set_over | (e_over & ~flag_clear);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("mix_out", int'($signed(mix_out)), e_out);
    check("mix_valid", int'(mix_valid), int'(e_valid));
    check("busy", int'(busy), int'(m_left > 0));
    check("clip", int'(clip), int'(e_clip));
    check("overrun", int'(overrun), int'(e_over));
  end

  task automatic frame(input string name, input logic [31:0] d, input logic [31:0] g,
                       input logic [3:0] m, input logic [3:0] s,
                       input int exp_out, input bit exp_clip);
    int cyc;
    @(negedge clk);
    track_data = d; track_gain = g; mute = m; solo = s; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    cyc = 1;
    while (!mix_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, N + 2);
    check({name, " out"}, int'($signed(mix_out)), exp_out);
    check({name, " clip"}, int'(clip), int'(exp_clip));
  endtask

  task automatic pulse_clear();
    @(negedge clk); flag_clear = 1'b1;
    @(negedge clk); flag_clear = 1'b0;
  endtask

  localparam logic [31:0] G64 = {8'd64, 8'd64, 8'd64, 8'd64};

  initial begin
    int r, cyc, pulses;
    bit c;
    rst = 1'b0; sample_valid = 1'b0; track_data = '0; track_gain = '0;
    mute = '0; solo = '0; flag_clear = 1'b0;

    // Pin the model to hand-computed values.
    model_mix(pack4(10, 20, -5, 3), G64, 4'b0000, 4'b0000, r, c);
    check("model unity", r, 28);
    model_mix(pack4(50, 0, 0, 0), {8'd0, 8'd0, 8'd0, 8'd255}, 4'b1110, 4'b0000, r, c);
    check("model 199 sat", r, 127);
    check("model 199 clip", int'(c), 1);
    model_mix(pack4(-1, 0, 0, 0), {8'd0, 8'd0, 8'd0, 8'd32}, 4'b1110, 4'b0000, r, c);
    check("model floor", r, -1);

    @(negedge clk);
    check("reset out", int'(mix_out), 0);
    check("reset busy", int'(busy), 0);
    @(posedge clk); #2 rst = 1'b1;

    frame("unity", pack4(10, 20, -5, 3), G64, 4'b0000, 4'b0000, 28, 0);
    frame("mute/solo", pack4(10, 20, 30, 40), G64, 4'b0001, 4'b0110, 50, 0);
    frame("all muted", pack4(10, 20, 30, 40), G64, 4'b1111, 4'b0000, 0, 0);
    frame("floor -1", pack4(-1, 0, 0, 0), {8'd0, 8'd0, 8'd0, 8'd32}, 4'b1110, 4'b0000, -1, 0);
    frame("floor 0", pack4(1, 0, 0, 0), {8'd0, 8'd0, 8'd0, 8'd32}, 4'b1110, 4'b0000, 0, 0);
    frame("gain 255", pack4(50, 0, 0, 0), {8'd0, 8'd0, 8'd0, 8'd255}, 4'b1110, 4'b0000, 127, 1);
    pulse_clear();
    check("clip cleared 1", int'(clip), 0);
    frame("sat pos", pack4(100, 100, 0, 0), G64, 4'b0000, 4'b0000, 127, 1);
    frame("sat neg", pack4(-100, -100, 0, 0), G64, 4'b0000, 4'b0000, -128, 1);
    pulse_clear();
    check("clip cleared 2", int'(clip), 0);

    // Overrun: strobes at cycles 0 and 3, inputs changed at cycle 1.
    @(negedge clk);
    track_data = pack4(10, 20, -5, 3); track_gain = G64; mute = '0; solo = '0;
    sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0; track_data = pack4(-50, -50, -50, -50);
    @(negedge clk);
    @(negedge clk); sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    cyc = 4; pulses = 0;
    while (cyc < 6) begin @(negedge clk); cyc++; if (mix_valid) pulses++; end
    check("ovr pulse cycle 6", int'(mix_valid), 1);
    check("ovr single pulse", pulses, 1);
    check("ovr out", int'($signed(mix_out)), 28);
    check("ovr flag", int'(overrun), 1);
    sample_valid = 1'b1;
    track_data = pack4(1, 2, 3, 4);
    @(negedge clk); sample_valid = 1'b0;
    cyc = 7;
    while (!mix_valid && cyc < 30) begin @(negedge clk); cyc++; end
    check("ovr next cycle", cyc, 12);
    check("ovr next out", int'($signed(mix_out)), 10);
    pulse_clear();
    check("ovr cleared", int'(overrun), 0);

    // Reset mid-frame.
    frame("pre-reset", pack4(5, 5, 5, 5), G64, 4'b0000, 4'b0000, 20, 0);
    @(negedge clk);
    track_data = pack4(7, 7, 7, 7); sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("rst out", int'(mix_out), 0);
    check("rst busy", int'(busy), 0);
    check("rst clip", int'(clip), 0);
    check("rst overrun", int'(overrun), 0);
    @(posedge clk); #2 rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (mix_valid) pulses++; end
    check("rst no pulse", pulses, 0);
    frame("post-reset", pack4(10, 20, -5, 3), G64, 4'b0000, 4'b0000, 28, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
